// File: rtl/cpu_lab_pkg.sv
// cpu_lab_pkg: definitions shared across the lab CPU system.
//   state_t    - run/step controller state encoding (also shown on the LEDs
//                and decoded by the display block)
//   STEP_CNT_W - width of the issued-instruction counter
package cpu_lab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw, bouncing push button into clk_in and
// only accepts a new level after DEBOUNCE_CYCLES consecutive samples that
// disagree with the current debounced level.
// Ports:
//   clk_in - system clock
//   rst    - asynchronous active-low reset
//   din    - raw asynchronous button input
//   level  - debounced button level
//   rise   - one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive samples that disagree with the debounced level; any
  // agreeing sample restarts the count, so a bounce resets the wait.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_rise <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run/step controller for the lab CPU. Converts rising edges
// of the clock divider output into single-cycle cpu_en pulses, either on
// every slow edge (RUN) or once per debounced button press (STEP). A CPU
// halt freezes issue until reset.
// Ports:
//   clk_in   - system clock (only clock)
//   rst      - asynchronous active-low reset
//   slow_clk - divider output, already registered in clk_in
//   mode_run - asynchronous board switch, 1 = RUN, 0 = step mode
//   step_btn - raw bouncing push button, active-high
//   halt     - CPU halt flag, clk_in domain
//   cpu_en   - registered single-cycle instruction enable
//   step_cnt - number of cpu_en pulses issued, wraps
//   state    - controller state for the LEDs
module cpu_step_ctrl
  import cpu_lab_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  slow_clk,
  input  logic                  mode_run,
  input  logic                  step_btn,
  input  logic                  halt,
  output logic                  cpu_en,
  output logic [STEP_CNT_W-1:0] step_cnt,
  output logic [1:0]            state
);

  logic                  r_mode_s1;
  logic                  r_mode_s2;
  logic                  r_slow_d;
  state_t                r_state;
  logic                  r_cpu_en;
  logic [STEP_CNT_W-1:0] r_step_cnt;

  state_t                w_state_nxt;
  logic                  w_issue;
  logic                  w_tick;
  logic                  w_btn_level;
  logic                  w_btn_rise;
  logic                  w_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_debounce (
    .clk_in (clk_in),
    .rst    (rst),
    .din    (step_btn),
    .level  (w_btn_level),
    .rise   (w_btn_rise)
  );

  // A rise pulse is only meaningful while the debounced level is high.
  assign w_press = w_btn_rise & w_btn_level;

  // Two-flop synchronizer for the mode switch.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
    end else begin
      r_mode_s1 <= mode_run;
      r_mode_s2 <= r_mode_s1;
    end
  end

  // Delayed copy of slow_clk for rising-edge detection.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_slow_d <= 1'b0;
    end else begin
      r_slow_d <= slow_clk;
    end
  end

  assign w_tick = slow_clk & ~r_slow_d;

  // Next state and issue decision; halt always wins, and a tick that
  // coincides with a halt or a mode drop is swallowed.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (halt) begin
          w_state_nxt = ST_HALTED;
        end else if (r_mode_s2) begin
          w_state_nxt = ST_RUN;
        end else if (w_press) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt) begin
          w_state_nxt = ST_HALTED;
        end else if (!r_mode_s2) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_issue = w_tick;
        end
      end
      ST_STEP: begin
        // Presses and mode changes are ignored until back in IDLE.
        if (halt) begin
          w_state_nxt = ST_HALTED;
        end else if (w_tick) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, registered enable and wrapping issue counter.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cpu_en   <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_en <= w_issue;
      if (w_issue) begin
        r_step_cnt <= r_step_cnt + STEP_CNT_W'(1);
      end else begin
        r_step_cnt <= r_step_cnt;
      end
    end
  end

  assign cpu_en   = r_cpu_en;
  assign step_cnt = r_step_cnt;
  assign state    = r_state;

endmodule
